mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Sequences the multi-cycle multiply/divide resource (HI/LO registers) beside the single-cycle E-stage ALU of the MIPS pipeline.
- Accepts one MDU instruction per cycle from the E stage and runs the multiply/divide latency with a down-counter.
- Drives busy and a D-stage stall request so that later MDU instructions (including mfhi/mflo) wait until HI/LO are final.
- Honours a flush from the interrupt/exception logic, so a cancelled instruction never touches HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mdu_op  input  4  E-stage MDU opcode (encodings in constants.v).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- flush  input  1  E-stage instruction cancelled this cycle; mdu_op is ignored.
- d_is_mdu  input  1  D-stage instruction is any MDU op.
- busy  output  1  a multiply/divide is in flight.
- stall_req  output  1  stall D stage.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- rd_data  output  32  mfhi/mflo result for the E stage.

Behaviour:
- Reset: state=IDLE, busy=0, hi=0, lo=0, count=0, operand/result shadows=0. Reset mid-operation abandons the operation; HI/LO are not updated.
- op_valid = (mdu_op != MDU_NONE) & ~flush.
- A start is op_valid with mdu_op in {MULT, MULTU, DIV, DIVU}.
- States: IDLE and RUN.
- IDLE, on a start at edge t0:
  - Compute the result into shadow registers res_hi/res_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 during cycles t0+1 through t0+N.
- RUN: count decrements every edge. On the edge where count==1, copy res_hi/res_lo into hi/lo, clear busy, return to IDLE. New HI/LO are visible from cycle t0+N+1.
- MTHI/MTLO: only in IDLE; write rs_val into hi or lo at the edge; single cycle; busy stays 0.
- Any op_valid arriving while in RUN is ignored. The stall makes this unreachable; the bench checks it by assertion.
- mult: signed 64-bit product, {hi,lo}. multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned.
  - INT_MIN / -1: lo=0x80000000, hi=0.
  - Divide by zero (rt_val==0): hi/lo unchanged at completion, but the full DIV_CYCLES busy period still elapses.
- rd_data (combinational) = hi when mdu_op==MFHI, lo when mdu_op==MFLO, else 0. It is valid only when busy=0; stall guarantees this.
- stall_req (combinational) = d_is_mdu & (busy | start_this_cycle).
- Simultaneous events:
  - flush together with a start: no start, no stall contribution from start.
  - reset overrides everything.

Decomposition:
- constants.v gains a 4-bit MDU opcode set: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
- Arithmetic lives in one sub-module, mdu_arith: combinational, takes op/rs/rt, produces 64-bit {hi,lo} plus a div_by_zero flag.
- FSM, counter and stall logic stay in mdu_sequencer.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3:
  - busy high for exactly 5 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA visible on cycle 6.
  - mflo in the following cycle gives rd_data=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rs=7, rt=2: lo=3, hi=1.
- Divide by zero: preset hi=0x11, lo=0x22; div rt=0 → busy for 10 cycles, then hi=0x11, lo=0x22.
- Stall, multu 0x80000000*2 with d_is_mdu=1 held:
  - stall_req=1 on the start cycle and all 5 busy cycles, 0 afterwards.
  - Result: hi=1, lo=0.
- Flush and reset:
  - mult with flush=1 → busy stays 0, hi/lo unchanged.
  - mthi rs=0xABCD → hi=0xABCD next cycle.
  - Reset asserted on the 3rd busy cycle of a div → busy=0, hi=lo=0 next cycle, no late write.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - MDU opcode set, FSM states and counter width
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide producing {hi,lo}
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] sdiv;
  logic [31:0] udiv;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic        rt_zero;

  assign rt_zero = (rt == 32'd0);

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide on magnitudes; INT_MIN/-1 falls out as 0x80000000 rem 0.
  assign mag_rs = rs[31] ? (32'd0 - rs) : rs;
  assign mag_rt = rt[31] ? (32'd0 - rt) : rt;
  assign sdiv   = rt_zero ? 32'd1 : mag_rt;
  assign udiv   = rt_zero ? 32'd1 : rt;
  assign mag_q  = mag_rs / sdiv;
  assign mag_r  = mag_rs % sdiv;
  assign quot_s = (rs[31] ^ rt[31]) ? (32'd0 - mag_q) : mag_q;
  assign rem_s  = rs[31] ? (32'd0 - mag_r) : mag_r;
  assign quot_u = rs / udiv;
  assign rem_u  = rs % udiv;

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      MULT:  result = prod_s;
      MULTU: result = prod_u;
      DIV: begin
        result      = {rem_s, quot_s};
        div_by_zero = rt_zero;
      end
      DIVU: begin
        result      = {rem_u, quot_u};
        div_by_zero = rt_zero;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - HI/LO owner: latency counter, busy and D-stage stall
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state;
  mdu_state_e       state_nx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dbz;
  logic [63:0]      arith_result;
  logic             arith_dbz;
  logic             op_valid;
  logic             is_arith;
  logic             is_div;
  logic             start;
  logic             done;

  mdu_arith u_arith (
    .op          (mdu_op),
    .rs          (rs_val),
    .rt          (rt_val),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  assign op_valid = (mdu_op != MDU_NONE) & ~flush;
  assign is_div   = (mdu_op == DIV) | (mdu_op == DIVU);
  assign is_arith = (mdu_op == MULT) | (mdu_op == MULTU) | is_div;
  assign start    = op_valid & is_arith & (state == S_IDLE);
  assign done     = (state == S_RUN) & (count == CNT_ONE);

  always_comb begin
    state_nx = state;
    count_nx = count;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
          count_nx = is_div ? DIV_CNT : MULT_CNT;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        count_nx = count - CNT_ONE;
        if (count == CNT_ONE) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign stall_req = d_is_mdu & (busy | start);

  always_comb begin
    rd_data = '0;
    if (mdu_op == MFHI) begin
      rd_data = hi;
    end else if (mdu_op == MFLO) begin
      rd_data = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      res_dbz <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (start) begin
        res_hi  <= arith_result[63:32];
        res_lo  <= arith_result[31:0];
        res_dbz <= arith_dbz;
      end
      // Divide by zero still burns the full latency but leaves HI/LO alone.
      if (done && !res_dbz) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if ((state == S_IDLE) && op_valid) begin
        if (mdu_op == MTHI) hi <= rs_val;
        if (mdu_op == MTLO) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_is_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .d_is_mdu  (d_is_mdu),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endfunction

  // Architectural reference: plain signed/unsigned arithmetic on HI/LO.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              q;
    int              r;
    case (op)
      MULT: begin
        p    = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MULTU: begin
        pu   = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
          end else begin
            q    = $signed(a) / $signed(b);
            r    = $signed(a) % $signed(b);
            m_lo = q;
            m_hi = r;
          end
        end
      end
      DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    int   run_len;
    logic prev_busy;
    run_len   = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_hi", 64'(hi), 64'(e.hi));
          chk("done_lo", 64'(lo), 64'(e.lo));
          chk("busy_len", 64'(run_len), 64'(e.cycles));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    exp_t e;
    model(op, a, b);
    e.hi     = m_hi;
    e.lo     = m_lo;
    e.cycles = (op == DIV || op == DIVU) ? DC : MC;
    sb.push_back(e);
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
    if (inject) begin
      rs_val = $urandom;
      rt_val = $urandom;
      mdu_op = 4'($urandom_range(1, 8));
      @(posedge clk); #1;
      mdu_op = MDU_NONE;
    end
    wait_idle();
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    model(op, v, 32'd0);
    mdu_op = op;
    rs_val = v;
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
    @(negedge clk);
    chk("mt_hi", 64'(hi), 64'(m_hi));
    chk("mt_lo", 64'(lo), 64'(m_lo));
    chk("mt_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic read_check(input logic [3:0] op, input logic [31:0] exp, input string name);
    mdu_op = op;
    @(negedge clk);
    chk(name, 64'(rd_data), 64'(exp));
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    reset    = 1'b1;
    mdu_op   = MDU_NONE;
    rs_val   = '0;
    rt_val   = '0;
    flush    = 1'b0;
    d_is_mdu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    @(posedge clk); #1;

    run_arith(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    read_check(MFLO, 32'hFFFF_FFFA, "mflo");
    read_check(MFHI, 32'hFFFF_FFFF, "mfhi");

    run_arith(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_arith(DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);

    mt(MTHI, 32'h11);
    mt(MTLO, 32'h22);
    run_arith(DIV, 32'd5, 32'd0, 1'b0);
    chk("dbz_hi", 64'(hi), 64'h11);
    chk("dbz_lo", 64'(lo), 64'h22);

    run_arith(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'd0);

    // Stall window: start cycle plus every busy cycle.
    d_is_mdu = 1'b1;
    model(MULTU, 32'h8000_0000, 32'd2);
    e.hi = m_hi; e.lo = m_lo; e.cycles = MC;
    sb.push_back(e);
    mdu_op = MULTU;
    rs_val = 32'h8000_0000;
    rt_val = 32'd2;
    @(negedge clk);
    chk("stall_start", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
    for (int k = 0; k < MC; k++) begin
      @(negedge clk);
      chk("stall_busy", 64'(stall_req), 64'd1);
    end
    @(negedge clk);
    chk("stall_after", 64'(stall_req), 64'd0);
    d_is_mdu = 1'b0;
    @(posedge clk); #1;
    chk("multu_hi", 64'(hi), 64'd1);
    chk("multu_lo", 64'(lo), 64'd0);

    // Flushed start must neither run nor stall.
    d_is_mdu = 1'b1;
    mdu_op   = MULT;
    rs_val   = 32'd1234;
    rt_val   = 32'd77;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    mdu_op   = MDU_NONE;
    flush    = 1'b0;
    d_is_mdu = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;

    mt(MTHI, 32'hABCD);
    chk("mthi_abcd", 64'(hi), 64'hABCD);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      if (sel < 8) run_arith(4'(1 + (sel % 4)), a, b, ($urandom_range(0, 2) == 0));
      else mt((sel == 8) ? MTHI : MTLO, a);
    end

    // Reset during the third busy cycle of a divide abandons it.
    mt(MTHI, 32'h55);
    e.hi = 32'd0; e.lo = 32'd0; e.cycles = 3;
    sb.push_back(e);
    mdu_op = DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    repeat (12) @(negedge clk);
    chk("late_hi", 64'(hi), 64'd0);
    chk("late_lo", 64'(lo), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
